// File: rtl/pipe_pkg.sv
// Shared constants for the execute-to-memory skid pipeline stage:
// FSM state encoding (value equals occupancy), zero word and NOP address.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam int unsigned      MAX_W        = 64;
  localparam logic [MAX_W-1:0] ZERO_WORD    = '0;
  localparam int unsigned      NOP_ADDR_DEF = 0;

endpackage

// File: rtl/pipe_skid_ctl.sv
// Control for the skid stage: occupancy FSM, registered in_ready and the
// load selects that steer the main/skid payload registers in the top.
module pipe_skid_ctl
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush_i,
  input  logic       in_valid_i,
  input  logic       out_ready_i,
  output logic       in_ready_o,
  output logic       out_valid_o,
  output logic       load_main_in_o,
  output logic       load_main_skid_o,
  output logic       load_skid_o,
  output logic       clear_main_o,
  output logic [1:0] state_o
);

  state_e state_q, state_d;
  logic   in_ready_q;
  logic   accept;
  logic   consume;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and in_ready is a pure flop.
  assign accept      = in_valid_i && in_ready_q && !flush_i;
  assign out_valid_o = (state_q != ST_EMPTY);
  assign consume     = out_valid_o && out_ready_i;

  always_comb begin
    state_d          = state_q;
    load_main_in_o   = 1'b0;
    load_main_skid_o = 1'b0;
    load_skid_o      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d        = ST_ONE;
          load_main_in_o = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && !consume) begin
          state_d     = ST_FULL;
          load_skid_o = 1'b1;
        end else if (!accept && consume) begin
          state_d = ST_EMPTY;
        end else if (accept && consume) begin
          load_main_in_o = 1'b1;
        end
      end
      ST_FULL: begin
        if (consume) begin
          state_d          = ST_ONE;
          load_main_skid_o = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush_i) begin
      state_d          = ST_EMPTY;
      load_main_in_o   = 1'b0;
      load_main_skid_o = 1'b0;
      load_skid_o      = 1'b0;
    end
  end

  // Main register must read as NOP whenever the stage is empty.
  assign clear_main_o = (state_d == ST_EMPTY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  assign in_ready_o = in_ready_q;
  assign state_o    = state_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Execute-to-memory pipeline register with one skid entry; outputs come
// straight from the main register, the skid entry absorbs a stalled push.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter int              ADDR_W   = 5,
  parameter logic [ADDR_W-1:0] NOP_ADDR = ADDR_W'(NOP_ADDR_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_wd_addr,
  input  logic              in_wreg,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_wd_addr,
  output logic              out_wreg,
  output logic [DATA_W-1:0] out_wdata,
  output logic [1:0]        occupancy
);

  localparam logic [DATA_W-1:0] ZERO_DATA = DATA_W'(ZERO_WORD);

  logic load_main_in, load_main_skid, load_skid, clear_main;

  logic [ADDR_W-1:0] main_addr_q, main_addr_d, skid_addr_q, skid_addr_d;
  logic              main_wreg_q, main_wreg_d, skid_wreg_q, skid_wreg_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;

  pipe_skid_ctl u_ctl (
    .clk              (clk),
    .rst              (rst),
    .flush_i          (flush),
    .in_valid_i       (in_valid),
    .out_ready_i      (out_ready),
    .in_ready_o       (in_ready),
    .out_valid_o      (out_valid),
    .load_main_in_o   (load_main_in),
    .load_main_skid_o (load_main_skid),
    .load_skid_o      (load_skid),
    .clear_main_o     (clear_main),
    .state_o          (occupancy)
  );

  always_comb begin
    main_addr_d = main_addr_q;
    main_wreg_d = main_wreg_q;
    main_data_d = main_data_q;
    if (clear_main) begin
      main_addr_d = NOP_ADDR;
      main_wreg_d = 1'b0;
      main_data_d = ZERO_DATA;
    end else if (load_main_in) begin
      main_addr_d = in_wd_addr;
      main_wreg_d = in_wreg;
      main_data_d = in_wdata;
    end else if (load_main_skid) begin
      main_addr_d = skid_addr_q;
      main_wreg_d = skid_wreg_q;
      main_data_d = skid_data_q;
    end
  end

  always_comb begin
    skid_addr_d = skid_addr_q;
    skid_wreg_d = skid_wreg_q;
    skid_data_d = skid_data_q;
    if (load_skid) begin
      skid_addr_d = in_wd_addr;
      skid_wreg_d = in_wreg;
      skid_data_d = in_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_addr_q <= NOP_ADDR;
      main_wreg_q <= 1'b0;
      main_data_q <= ZERO_DATA;
    end else begin
      main_addr_q <= main_addr_d;
      main_wreg_q <= main_wreg_d;
      main_data_q <= main_data_d;
    end
  end

  // Skid contents only reach the outputs via a load into main, so no reset.
  always_ff @(posedge clk) begin
    skid_addr_q <= skid_addr_d;
    skid_wreg_q <= skid_wreg_d;
    skid_data_q <= skid_data_d;
  end

  assign out_wd_addr = main_addr_q;
  assign out_wreg    = main_wreg_q;
  assign out_wdata   = main_data_q;

endmodule
